pixel_feeder: RTL
=================

# pixel_feeder

Upstream pixel source for the TFT/SDRAM controller. Runs a post-reset frame-buffer clear, then accepts RGB565 pixels from an 8-bit host byte port into a 16-word first-word-fall-through FIFO. It drives the controller's write-side inputs: page select, row/column write address, FIFO status/data and `startup`. It advances the write address on each controller write-complete pulse.

## Interface
- `FIFO_DEPTH`, 16: word FIFO depth, power of two.
- `FIFO_THRESH`, 1: minimum FIFO level at which `fifo_full` is asserted.
- `CLEAR_COLOR`, 16'h0000: RGB565 word written during the clear pass.
- `clk`  in  1  system clock, same domain as the SDRAM controller.
- `rst`  in  1  reset, asynchronous, active-low.
- `host_wr`  in  1  single-cycle byte strobe.
- `host_cmd`  in  1  qualifies `host_data` as a command (1) or a pixel byte (0).
- `host_data`  in  8  byte from the host.
- `host_ready`  out  1  the host may strobe this cycle.
- `overflow`  out  1  sticky: a byte was dropped; cleared only by reset.
- `startup`  out  1  0 during the clear pass, 1 afterwards.
- `page_set`  out  3  write page.
- `page_show`  out  3  display page.
- `row_add_user`  out  9  write row, 0..479.
- `col_add_user`  out  10  write column, 0..799.
- `startup_inc`  in  1  controller write-complete pulse; advances the address.
- `fifo_rd_req`  in  1  pop the FIFO head.
- `fifo_full`  out  1  FIFO level ≥ `FIFO_THRESH`; forced 0 while `startup`=0.
- `fifo_out`  out  16  FIFO head (FWFT); `CLEAR_COLOR` while `startup`=0.

## Operation
- **Reset values:** `startup`=0, `page_set`=0, `page_show`=0, row=0, col=0, FIFO empty, `fifo_full`=0, `host_ready`=0, `overflow`=0. The byte-pending flag is cleared.
- **States:** CLEAR → IDLE ⇄ PIX_HI/PIX_LO.
- **CLEAR:**
  - Each `startup_inc` advances the address.
  - After the last page's row 479, col 799, go to IDLE: `startup`←1, address←0/0, `page_set`←0.
  - `host_ready`=0 throughout.
- **Address step on `startup_inc`:**
  - col+1.
  - col 799 → col 0, row+1.
  - row 479 with col 799 → row 0, and in CLEAR page+1. After CLEAR the page is not changed.
- **Pixel bytes** (`host_cmd`=0): the first byte is latched as `[15:8]`. The second completes the word and pushes it.
- **FIFO push with level == `FIFO_DEPTH`:** word dropped, `overflow`←1.
- **`host_ready` outside CLEAR:** 1 when level ≤ `FIFO_DEPTH`-2.
- **Commands** (`host_cmd`=1):
  - Accepted only when the FIFO is empty. A command while not empty is dropped and sets `overflow`.
  - A pending high byte is discarded.
  - `8'h1p`: `page_set`←p[2:0], address←0/0.
  - `8'h2p`: `page_show`←p[2:0].
  - `8'h30`: address←0/0.
  - Any other command: ignored.
- **Pops:** `fifo_rd_req` with an empty FIFO is ignored. A simultaneous push and pop leaves the level unchanged.

## Timing
- Second pixel byte at edge N → word in FIFO, level updated after edge N. `fifo_out` and `fifo_full` are valid in cycle N+1.
- `fifo_full` and `fifo_out` are combinational from the level and read pointer. No extra register stage.
- The address updates at the edge after `startup_inc` is sampled.
- Command effects are visible the cycle after the strobe edge.
- `startup` rises at the edge that consumes the final clear `startup_inc`.
- Reset mid-operation restarts CLEAR. FIFO contents and the pending byte are lost.

## Configuration
- `FEEDER_CLEAR_ALL_PAGES_EN` defined: CLEAR covers pages 0..7, 3,072,000 writes.
- Undefined: CLEAR covers page 0 only, 384,000 writes. `page_set` stays 0 during CLEAR.

## Structure
- Shared package `tft_pkg`:
  - `H_ACTIVE`=800, `V_ACTIVE`=480.
  - Opcode constants `CMD_SET_PAGE`=4'h1, `CMD_SHOW_PAGE`=4'h2, `CMD_HOME`=4'h3.
  - `pixel_t` (16-bit RGB565).
  - State enum.
- One sub-module, `pixel_fifo`: FWFT, parameterised depth, level output, ignores pop on empty, reports push-on-full.

## Test plan
- **Clear pass.** Reset, then `startup_inc` every 4 cycles, macro undefined. Expect 384,000 pulses, then `startup`=1 and row=col=0. `fifo_out`=0000 and `fifo_full`=0 throughout.
- **Pixel push.** After startup, bytes 0xF8, 0x00. Expect `fifo_full`=1 the cycle after the second byte, `fifo_out`=F800. `fifo_rd_req` → empty, `fifo_full`=0.
- **Address wrap.** Address at row 479, col 799, `startup_inc`. Expect row 0, col 0, `page_set` unchanged.
- **Overflow.** Push 17 words with no pops. Expect `host_ready`=0 at level 15, the 17th word dropped, `overflow`=1, the first 16 words popped intact in order.
- **Command gating.** FIFO holds 1 word, command 0x15 → ignored, `overflow`=1. Pop, then 0x15 → `page_set`=5, address 0/0. Command 0x23 → `page_show`=3.
- **Reset mid-clear.** Assert `rst` mid-CLEAR. Expect all outputs back to reset values and CLEAR restarting from address 0.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT/SDRAM pixel path: panel geometry, host
// command opcodes, the RGB565 pixel type and the pixel_feeder state encoding.
package tft_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;

    localparam logic [3:0] CMD_SET_PAGE  = 4'h1;
    localparam logic [3:0] CMD_SHOW_PAGE = 4'h2;
    localparam logic [3:0] CMD_HOME      = 4'h3;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_PIX_HI = 2'd2,
        S_PIX_LO = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through word FIFO. The head is always visible on dout;
// pops on an empty FIFO are ignored and pushes on a full FIFO are dropped
// and reported through push_drop.
module pixel_fifo
    import tft_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pixel_t                   din,
    input  logic                     pop,
    output pixel_t                   dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign push_drop = push && full;
    assign dout      = mem[rd_ptr];

    // Pointer and level bookkeeping; a simultaneous push and pop nets to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_feeder.sv
// Pixel source for the TFT/SDRAM controller: clears the frame buffer after
// reset, then packs host bytes into RGB565 words through a FWFT FIFO and
// tracks the controller write address.
// Build option: FEEDER_CLEAR_ALL_PAGES_EN makes the clear pass cover pages
// 0..7 instead of page 0 only.
module pixel_feeder
    import tft_pkg::*;
#(
    parameter int     FIFO_DEPTH  = 16,
    parameter int     FIFO_THRESH = 1,
    parameter pixel_t CLEAR_COLOR = 16'h0000,
    parameter int     COLS        = H_ACTIVE,
    parameter int     ROWS        = V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_wr,
    input  logic       host_cmd,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       overflow,
    output logic       startup,
    output logic [2:0] page_set,
    output logic [2:0] page_show,
    output logic [8:0] row_add_user,
    output logic [9:0] col_add_user,
    input  logic       startup_inc,
    input  logic       fifo_rd_req,
    output logic       fifo_full,
    output pixel_t     fifo_out
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef FEEDER_CLEAR_ALL_PAGES_EN
    localparam logic [2:0] LAST_PAGE = 3'd7;
`else
    localparam logic [2:0] LAST_PAGE = 3'd0;
`endif

    feeder_state_t   state;
    feeder_state_t   state_nx;
    logic [LW-1:0]   level;
    pixel_t          head;
    logic            fifo_drop;
    logic            push;
    logic            latch_hi;
    logic            cmd_ok;
    logic            cmd_drop;
    logic [7:0]      hi_byte;
    logic            last_col;
    logic            last_row;
    logic            clear_done;

    assign last_col   = (col_add_user == 10'(COLS - 1));
    assign last_row   = (row_add_user == 9'(ROWS - 1));
    assign clear_done = (state == S_CLEAR) && startup_inc && last_col && last_row
                        && (page_set == LAST_PAGE);

    assign startup    = (state != S_CLEAR);
    assign fifo_full  = startup && (level >= LW'(FIFO_THRESH));
    assign fifo_out   = startup ? head : CLEAR_COLOR;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       ({hi_byte, host_data}),
        .pop       (fifo_rd_req),
        .dout      (head),
        .level     (level),
        .push_drop (fifo_drop)
    );

    // State register; reset always restarts the clear pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_CLEAR;
        else      state <= state_nx;
    end

    // Next state plus host-side strobes: byte pairing, command gating, ready.
    always_comb begin
        state_nx   = state;
        push       = 1'b0;
        latch_hi   = 1'b0;
        cmd_ok     = 1'b0;
        cmd_drop   = 1'b0;
        host_ready = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clear_done) state_nx = S_IDLE;
            end
            default: begin
                host_ready = (level <= LW'(FIFO_DEPTH - 2));
                if (host_wr) begin
                    if (host_cmd) begin
                        state_nx = S_IDLE;
                        if (level == '0) cmd_ok   = 1'b1;
                        else             cmd_drop = 1'b1;
                    end else if (state == S_PIX_LO) begin
                        push     = 1'b1;
                        state_nx = S_PIX_HI;
                    end else begin
                        latch_hi = 1'b1;
                        state_nx = S_PIX_LO;
                    end
                end
            end
        endcase
    end

    // High pixel byte holding register.
    always_ff @(posedge clk) begin
        if (latch_hi) hi_byte <= host_data;
    end

    // Write page and row/column address; commands take priority over a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_set     <= '0;
            row_add_user <= '0;
            col_add_user <= '0;
        end else if (clear_done) begin
            page_set     <= '0;
            row_add_user <= '0;
            col_add_user <= '0;
        end else if (cmd_ok && host_data[7:4] == CMD_SET_PAGE) begin
            page_set     <= host_data[2:0];
            row_add_user <= '0;
            col_add_user <= '0;
        end else if (cmd_ok && host_data == {CMD_HOME, 4'h0}) begin
            row_add_user <= '0;
            col_add_user <= '0;
        end else if (startup_inc) begin
            if (last_col) begin
                col_add_user <= '0;
                if (last_row) begin
                    row_add_user <= '0;
                    if (state == S_CLEAR) page_set <= page_set + 1'b1;
                end else begin
                    row_add_user <= row_add_user + 1'b1;
                end
            end else begin
                col_add_user <= col_add_user + 1'b1;
            end
        end
    end

    // Display page select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          page_show <= '0;
        else if (cmd_ok && host_data[7:4] == CMD_SHOW_PAGE) page_show <= host_data[2:0];
    end

    // Sticky drop indicator for words pushed on full and commands on non-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       overflow <= 1'b0;
        else if (fifo_drop || cmd_drop) overflow <= 1'b1;
    end

endmodule
